// File: rtl/std_fp_sdiv_pipe.sv
// std_fp_sdiv_pipe: multi-cycle signed fixed-point divider with a go/done handshake.
// Computes the Q(INT_WIDTH.FRAC_WIDTH) quotient of left/right and a raw signed remainder.
// It uses restoring shift-subtract division on the operand magnitudes, producing one quotient
// bit per cycle. Signs are applied when the last iteration writes the result.
//
// Ports:
//   clk           - clock; all state updates on the rising edge
//   reset         - synchronous, active-high reset
//   go            - start/hold request; dropping it while busy aborts the operation
//   left, right   - signed dividend and divisor, sampled on the start edge only
//   out_quotient  - signed fixed-point quotient, registered
//   out_remainder - signed raw remainder (carries the sign of left), registered
//   done          - one-cycle completion pulse
module std_fp_sdiv_pipe #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned INT_WIDTH  = 16,
    parameter int unsigned FRAC_WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic             done
);

    // One iteration per bit of the pre-shifted dividend.
    localparam int unsigned N    = WIDTH + FRAC_WIDTH;
    localparam int unsigned CntW = $clog2(N + 1);

    if (INT_WIDTH + FRAC_WIDTH != WIDTH) begin : g_width_check
        $error("std_fp_sdiv_pipe: INT_WIDTH + FRAC_WIDTH must equal WIDTH");
    end

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e              state_q;
    logic [CntW-1:0]     cnt_q;
    logic [N-1:0]        dq_q;      // dividend bits shift out the top, quotient bits in the bottom
    logic [WIDTH-1:0]    rem_q;     // partial remainder magnitude, always < divisor
    logic [WIDTH-1:0]    div_q;     // divisor magnitude
    logic [WIDTH-1:0]    left_q;    // original dividend, returned as remainder on divide by zero
    logic                neg_q;     // quotient sign
    logic                lsign_q;   // remainder sign
    logic                dzero_q;

    logic [WIDTH-1:0] abs_left;
    logic [WIDTH-1:0] abs_right;
    logic [WIDTH:0]   rem_shift;
    logic             fits;
    logic [WIDTH-1:0] rem_next;
    logic [N-1:0]     dq_next;
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;

    always_comb begin
        // Magnitude of the most negative value wraps to itself, which is correct as unsigned.
        abs_left  = left[WIDTH-1]  ? -left  : left;
        abs_right = right[WIDTH-1] ? -right : right;

        rem_shift = {rem_q, dq_q[N-1]};
        fits      = rem_shift >= {1'b0, div_q};
        // When fits is set the difference is < divisor, so WIDTH bits suffice.
        rem_next  = fits ? (rem_shift[WIDTH-1:0] - div_q) : rem_shift[WIDTH-1:0];
        dq_next   = {dq_q[N-2:0], fits};

        if (dzero_q) begin
            q_final = lsign_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            r_final = left_q;
        end else begin
            // Quotient magnitude may exceed WIDTH bits; low bits are kept (wraps, no flag).
            q_final = neg_q   ? -dq_next[WIDTH-1:0] : dq_next[WIDTH-1:0];
            r_final = lsign_q ? -rem_next : rem_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            dq_q          <= '0;
            rem_q         <= '0;
            div_q         <= '0;
            left_q        <= '0;
            neg_q         <= 1'b0;
            lsign_q       <= 1'b0;
            dzero_q       <= 1'b0;
            out_quotient  <= '0;
            out_remainder <= '0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (go) begin
                        dq_q    <= {abs_left, {FRAC_WIDTH{1'b0}}};
                        rem_q   <= '0;
                        div_q   <= abs_right;
                        left_q  <= left;
                        neg_q   <= left[WIDTH-1] ^ right[WIDTH-1];
                        lsign_q <= left[WIDTH-1];
                        dzero_q <= (right == '0);
                        cnt_q   <= CntW'(N);
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    if (!go) begin
                        // Abort: outputs keep their previous values.
                        state_q <= StIdle;
                    end else begin
                        rem_q <= rem_next;
                        dq_q  <= dq_next;
                        cnt_q <= cnt_q - CntW'(1);
                        if (cnt_q == CntW'(1)) begin
                            out_quotient  <= q_final;
                            out_remainder <= r_final;
                            done          <= 1'b1;
                            state_q       <= StDone;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
